// File: rtl/uart_tx_pkg.sv
// Shared constants, register map and FSM encoding for the memory-mapped UART transmitter.
package uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_EMPTY = 2;
  localparam int unsigned ST_OVF   = 3;
  localparam int unsigned ST_CNT   = 4;
  localparam int unsigned ST_PAR   = 8;

  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } txState_e;

  function automatic logic [15:0] clampDiv(input logic [15:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte-wide synchronous FIFO; the caller never pushes while full unless also popping.
module tx_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;

  // Push into a full FIFO with a simultaneous pop overwrites the slot being read out.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rdPtr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus decode, registers and baud FSM.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit); default is 8N1.
module mmio_uart_tx
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_DIV  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Tx,
  output logic        TxBusy,
  output logic        TxEmptyIrq
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic          sel, wrEn, pushReq, pushAcc, popEn;
  logic [1:0]    idx;
  logic [7:0]    fifoDout;
  logic          fifoFull, fifoEmpty, nextEmpty;
  logic [CW-1:0] fifoCount;
  logic [4:0]    cntExt;
  logic [3:0]    cntNib;
  logic          overflow;
  logic [15:0]   baudDiv;
  logic          unusedBits;

  txState_e    state, nextState;
  logic [7:0]  shiftReg, nextShift;
  logic [15:0] baudCnt, nextBaud, divShadow, nextShadow;
  logic [2:0]  bitCnt, nextBit;
  logic        bitDone, startFrame;
`ifdef UART_TX_PARITY_EN
  logic        parityBit, nextPar;
`endif

  assign sel        = (Address[31:4] == BASE_ADDR[31:4]);
  assign idx        = Address[3:2];
  assign wrEn       = sel && MemWrite;
  assign pushReq    = wrEn && (idx == REG_TXDATA);
  assign pushAcc    = pushReq && (!fifoFull || popEn);
  assign unusedBits = ^{WriteData[31:16], Address[1:0]};

  tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushAcc),
    .pop   (popEn),
    .din   (WriteData[7:0]),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  assign bitDone = (baudCnt == divShadow - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState  = state;
    nextShift  = shiftReg;
    nextBaud   = baudCnt + 16'd1;
    nextBit    = bitCnt;
    nextShadow = divShadow;
    popEn      = 1'b0;
    startFrame = 1'b0;
`ifdef UART_TX_PARITY_EN
    nextPar    = parityBit;
`endif
    case (state)
      IDLE: begin
        nextBaud = '0;
        if (!fifoEmpty) startFrame = 1'b1;
      end
      START: if (bitDone) begin
        nextState = DATA;
        nextBaud  = '0;
        nextBit   = '0;
      end
      DATA: if (bitDone) begin
        nextBaud  = '0;
        nextShift = {1'b0, shiftReg[7:1]};
        if (bitCnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          nextState = PARITY;
`else
          nextState = STOP;
`endif
        end else begin
          nextBit = bitCnt + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bitDone) begin
        nextState = STOP;
        nextBaud  = '0;
      end
`endif
      STOP: if (bitDone) begin
        nextBaud = '0;
        if (!fifoEmpty) startFrame = 1'b1;
        else            nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // Popping from STOP chains frames with no idle gap on the line.
    if (startFrame) begin
      popEn      = 1'b1;
      nextState  = START;
      nextShift  = fifoDout;
      nextShadow = baudDiv;
      nextBaud   = '0;
`ifdef UART_TX_PARITY_EN
      nextPar    = ^fifoDout;
`endif
    end
  end

  always_comb begin
    Tx = 1'b1;
    case (state)
      START:   Tx = 1'b0;
      DATA:    Tx = shiftReg[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  Tx = parityBit;
`endif
      default: Tx = 1'b1;
    endcase
  end

  assign nextEmpty = !pushAcc && (fifoEmpty || ((fifoCount == CW'(1)) && popEn));

  always_ff @(posedge clk) begin
    if (reset) begin
      shiftReg   <= '0;
      baudCnt    <= '0;
      bitCnt     <= '0;
      divShadow  <= RESET_DIV;
      overflow   <= 1'b0;
      baudDiv    <= RESET_DIV;
      TxEmptyIrq <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parityBit  <= 1'b0;
`endif
    end else begin
      shiftReg   <= nextShift;
      baudCnt    <= nextBaud;
      bitCnt     <= nextBit;
      divShadow  <= nextShadow;
      TxEmptyIrq <= (nextState == IDLE) && nextEmpty;
`ifdef UART_TX_PARITY_EN
      parityBit  <= nextPar;
`endif
      if (wrEn && (idx == REG_STATUS) && WriteData[ST_OVF]) overflow <= 1'b0;
      else if (pushReq && !pushAcc)                         overflow <= 1'b1;
      if (wrEn && (idx == REG_BAUDDIV)) baudDiv <= clampDiv(WriteData[15:0]);
    end
  end

  assign TxBusy = (state != IDLE) || !fifoEmpty;
  assign cntExt = 5'(fifoCount);
  assign cntNib = (cntExt > 5'd15) ? 4'hF : cntExt[3:0];

  always_comb begin
    ReadData = '0;
    if (sel && MemRead) begin
      case (idx)
        REG_STATUS: begin
          ReadData[ST_BUSY]     = TxBusy;
          ReadData[ST_FULL]     = fifoFull;
          ReadData[ST_EMPTY]    = fifoEmpty;
          ReadData[ST_OVF]      = overflow;
          ReadData[ST_CNT +: 4] = cntNib;
          ReadData[ST_PAR]      = PAR_EN;
        end
        REG_BAUDDIV: ReadData[15:0] = baudDiv;
        default:     ReadData = '0;
      endcase
    end
  end

endmodule
